prog_mem_arbiter: RTL and testbench

Single-port access controller for the program memory. Arbitrates between the core's instruction-fetch port (read-only) and the loader/debug port (read/write), drives the memory's enable/write/address lines, and returns read data with a one-cycle valid strobe to whichever requester issued the access. It sits between the core front end, the program loader and the program memory array, and is the only agent that drives the memory.

---
 rtl/prog_mem_arbiter_if.sv | 41 ++++
 rtl/prog_mem_arbiter.sv | 89 ++++++++
 tb/tb_prog_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_arbiter_if.sv
// Bundle of requester-side handshakes and program-memory lines around prog_mem_arbiter.
// The arbiter takes the slave view; whoever models the requesters and memory takes master.
interface prog_mem_arbiter_if #(
    parameter int unsigned TAM  = 16,
    parameter int unsigned Lmem = 8,
    parameter int unsigned DW   = 16
);
    logic            core_req;
    logic [TAM-1:0]  core_addr;
    logic            core_gnt;
    logic            core_valid;
    logic [DW-1:0]   core_data;

    logic            ldr_req;
    logic            ldr_we;
    logic [TAM-1:0]  ldr_addr;
    logic [DW-1:0]   ldr_wdata;
    logic            ldr_gnt;
    logic            ldr_valid;
    logic [DW-1:0]   ldr_rdata;

    logic            mem_en;
    logic            mem_we;
    logic [Lmem-1:0] mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    logic            addr_err;

    modport slave (
        input  core_req, core_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
        output core_gnt, core_valid, core_data, ldr_gnt, ldr_valid, ldr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, addr_err
    );

    modport master (
        output core_req, core_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
        input  core_gnt, core_valid, core_data, ldr_gnt, ldr_valid, ldr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, addr_err
    );
endinterface

// File: rtl/prog_mem_arbiter.sv
// Round-robin single-port program memory arbiter between core fetch and loader/debug,
// returning read data with a one-cycle valid strobe to the access owner.
module prog_mem_arbiter #(
    parameter int unsigned TAM  = 16,
    parameter int unsigned Lmem = 8,
    parameter int unsigned DW   = 16
) (
    input logic                clk,
    input logic                rst,
    prog_mem_arbiter_if.slave  bus
);
    localparam logic [1:0] OwnNone  = 2'd0;
    localparam logic [1:0] OwnCore  = 2'd1;
    localparam logic [1:0] OwnLdr   = 2'd2;
    localparam logic       LastCore = 1'b0;
    localparam logic       LastLdr  = 1'b1;

    logic          last_q, last_d;
    logic [1:0]    owner_q, owner_d;
    logic          nop_q, nop_d;
    logic          err_q, err_d;
    logic [DW-1:0] core_hold_q, core_hold_d;
    logic [DW-1:0] ldr_hold_q, ldr_hold_d;

    logic          core_in_range, ldr_in_range, sel_in_range;
    logic          contested, gnt_core, gnt_ldr, gnt_any;
    logic          core_valid, ldr_valid;
    logic [DW-1:0] ret_data, core_data, ldr_rdata;

    always_comb begin
        core_in_range = (bus.core_addr >> Lmem) == '0;
        ldr_in_range  = (bus.ldr_addr >> Lmem) == '0;
        contested     = bus.core_req & bus.ldr_req;
        // Core wins unless the loader is also asking and the core took the last conflict.
        gnt_core      = rst & bus.core_req & (~bus.ldr_req | (last_q == LastLdr));
        gnt_ldr       = rst & bus.ldr_req & ~gnt_core;
        gnt_any       = gnt_core | gnt_ldr;
        sel_in_range  = gnt_core ? core_in_range : ldr_in_range;

        last_d = last_q;
        if (contested && gnt_any) begin
            last_d = gnt_core ? LastCore : LastLdr;
        end
        owner_d = gnt_core ? OwnCore : (gnt_ldr ? OwnLdr : OwnNone);
        // Out-of-range accesses and loader writes return the zero word instead of memory data.
        nop_d   = ~sel_in_range | (gnt_ldr & bus.ldr_we);
        err_d   = err_q | (gnt_any & ~sel_in_range);

        ret_data    = nop_q ? '0 : bus.mem_rdata;
        core_valid  = owner_q == OwnCore;
        ldr_valid   = owner_q == OwnLdr;
        core_data   = core_valid ? ret_data : core_hold_q;
        ldr_rdata   = ldr_valid ? ret_data : ldr_hold_q;
        core_hold_d = core_data;
        ldr_hold_d  = ldr_rdata;
    end

    always_comb begin
        bus.core_gnt   = gnt_core;
        bus.ldr_gnt    = gnt_ldr;
        bus.core_valid = core_valid;
        bus.core_data  = core_data;
        bus.ldr_valid  = ldr_valid;
        bus.ldr_rdata  = ldr_rdata;
        bus.mem_en     = gnt_any & sel_in_range;
        bus.mem_we     = gnt_ldr & bus.ldr_we & ldr_in_range;
        bus.mem_addr   = gnt_ldr ? bus.ldr_addr[Lmem-1:0] : bus.core_addr[Lmem-1:0];
        bus.mem_wdata  = bus.ldr_wdata;
        bus.addr_err   = err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q      <= LastLdr;
            owner_q     <= OwnNone;
            nop_q       <= 1'b0;
            err_q       <= 1'b0;
            core_hold_q <= '0;
            ldr_hold_q  <= '0;
        end else begin
            last_q      <= last_d;
            owner_q     <= owner_d;
            nop_q       <= nop_d;
            err_q       <= err_d;
            core_hold_q <= core_hold_d;
            ldr_hold_q  <= ldr_hold_d;
        end
    end
endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter with a synchronous single-port memory model.
module tb_prog_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [15:0] mem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    prog_mem_arbiter_if #(.TAM(16), .Lmem(8), .DW(16)) bus ();

    prog_mem_arbiter #(.TAM(16), .Lmem(8), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory: write on the enable edge, read data registered for the next cycle.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic idle_reqs();
        bus.core_req = 1'b0;
        bus.ldr_req = 1'b0;
        bus.ldr_we = 1'b0;
    endtask

    task automatic test_reset();
        bus.core_req = 1'b1;
        bus.ldr_req = 1'b1;
        bus.ldr_we = 1'b0;
        bus.core_addr = 16'h0000;
        bus.ldr_addr = 16'h0030;
        bus.ldr_wdata = 16'h0000;
        preload(8'h00, 16'hA5A5);
        preload(8'h04, 16'h1111);
        preload(8'h05, 16'h2222);
        preload(8'h06, 16'h3333);
        preload(8'h07, 16'h4444);
        preload(8'h20, 16'hC0DE);
        preload(8'h30, 16'h1DAD);
        tick();
        total++;
        if (bus.core_gnt !== 1'b0 || bus.ldr_gnt !== 1'b0 || bus.mem_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_grants: got cg=%b lg=%b en=%b want 0 0 0",
                     bus.core_gnt, bus.ldr_gnt, bus.mem_en);
        end
        total++;
        if (bus.core_valid !== 1'b0 || bus.ldr_valid !== 1'b0 || bus.addr_err !== 1'b0 ||
            bus.core_data !== 16'h0 || bus.ldr_rdata !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs: got cv=%b lv=%b err=%b cd=%h ld=%h want all 0",
                     bus.core_valid, bus.ldr_valid, bus.addr_err, bus.core_data, bus.ldr_rdata);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.core_gnt !== 1'b1 || bus.ldr_gnt !== 1'b0 || bus.mem_en !== 1'b1 ||
            bus.mem_addr !== 8'h00) begin
            bad++;
            $display("FAIL reset_first_conflict: got cg=%b lg=%b en=%b a=%h want 1 0 1 00",
                     bus.core_gnt, bus.ldr_gnt, bus.mem_en, bus.mem_addr);
        end
        tick();
        total++;
        if (bus.core_valid !== 1'b1 || bus.ldr_valid !== 1'b0 || bus.core_data !== 16'hA5A5) begin
            bad++;
            $display("FAIL reset_first_return: got cv=%b lv=%b cd=%h want 1 0 a5a5",
                     bus.core_valid, bus.ldr_valid, bus.core_data);
        end
        idle_reqs();
        tick();
    endtask

    task automatic test_core_stream();
        logic [15:0] exp [4];
        exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333; exp[3] = 16'h4444;
        for (int k = 0; k < 4; k++) begin
            bus.core_req = 1'b1;
            bus.core_addr = 16'(4 + k);
            #1;
            total++;
            if (bus.core_gnt !== 1'b1 || bus.ldr_gnt !== 1'b0) begin
                bad++;
                $display("FAIL stream_gnt[%0d]: got cg=%b lg=%b want 1 0",
                         k, bus.core_gnt, bus.ldr_gnt);
            end
            tick();
            total++;
            if (bus.core_valid !== 1'b1 || bus.core_data !== exp[k]) begin
                bad++;
                $display("FAIL stream_data[%0d]: got cv=%b cd=%h want 1 %h",
                         k, bus.core_valid, bus.core_data, exp[k]);
            end
        end
        idle_reqs();
        tick();
        total++;
        if (bus.core_valid !== 1'b0 || bus.core_data !== 16'h4444) begin
            bad++;
            $display("FAIL stream_hold: got cv=%b cd=%h want 0 4444", bus.core_valid, bus.core_data);
        end
    endtask

    task automatic test_contention();
        logic [5:0] core_turn;
        core_turn = 6'b010101;
        // Fresh reset so the core wins the first conflict again.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        bus.core_addr = 16'h0020;
        bus.ldr_addr = 16'h0030;
        bus.ldr_we = 1'b0;
        bus.core_req = 1'b1;
        bus.ldr_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (bus.core_gnt !== core_turn[i] || bus.ldr_gnt !== ~core_turn[i]) begin
                bad++;
                $display("FAIL contend_gnt[%0d]: got cg=%b lg=%b want %b %b",
                         i, bus.core_gnt, bus.ldr_gnt, core_turn[i], ~core_turn[i]);
            end
            tick();
            total++;
            if (bus.core_valid !== core_turn[i] || bus.ldr_valid !== ~core_turn[i]) begin
                bad++;
                $display("FAIL contend_valid[%0d]: got cv=%b lv=%b want %b %b",
                         i, bus.core_valid, bus.ldr_valid, core_turn[i], ~core_turn[i]);
            end
            total++;
            if (bus.core_data !== 16'hC0DE || (i > 0 && bus.ldr_rdata !== 16'h1DAD) ||
                (i == 0 && bus.ldr_rdata !== 16'h0000)) begin
                bad++;
                $display("FAIL contend_data[%0d]: got cd=%h ld=%h want c0de %h",
                         i, bus.core_data, bus.ldr_rdata, (i == 0) ? 16'h0000 : 16'h1DAD);
            end
        end
        idle_reqs();
        tick();
    endtask

    task automatic test_write_then_read();
        bus.ldr_req = 1'b1;
        bus.ldr_we = 1'b1;
        bus.ldr_addr = 16'h0010;
        bus.ldr_wdata = 16'hBEEF;
        #1;
        total++;
        if (bus.ldr_gnt !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 ||
            bus.mem_addr !== 8'h10 || bus.mem_wdata !== 16'hBEEF) begin
            bad++;
            $display("FAIL wr_drive: got lg=%b en=%b we=%b a=%h wd=%h want 1 1 1 10 beef",
                     bus.ldr_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        total++;
        if (bus.ldr_valid !== 1'b1 || bus.ldr_rdata !== 16'h0000) begin
            bad++;
            $display("FAIL wr_ack: got lv=%b ld=%h want 1 0000", bus.ldr_valid, bus.ldr_rdata);
        end
        idle_reqs();
        bus.core_req = 1'b1;
        bus.core_addr = 16'h0010;
        tick();
        total++;
        if (bus.core_valid !== 1'b1 || bus.core_data !== 16'hBEEF) begin
            bad++;
            $display("FAIL wr_readback: got cv=%b cd=%h want 1 beef", bus.core_valid, bus.core_data);
        end
        idle_reqs();
        tick();
    endtask

    task automatic test_out_of_range();
        bus.core_req = 1'b1;
        bus.core_addr = 16'h0100;
        #1;
        total++;
        if (bus.core_gnt !== 1'b1 || bus.mem_en !== 1'b0) begin
            bad++;
            $display("FAIL oor_drive: got cg=%b en=%b want 1 0", bus.core_gnt, bus.mem_en);
        end
        tick();
        total++;
        if (bus.core_valid !== 1'b1 || bus.core_data !== 16'h0000 || bus.addr_err !== 1'b1) begin
            bad++;
            $display("FAIL oor_return: got cv=%b cd=%h err=%b want 1 0000 1",
                     bus.core_valid, bus.core_data, bus.addr_err);
        end
        bus.core_req = 1'b0;
        bus.ldr_req = 1'b1;
        bus.ldr_we = 1'b1;
        bus.ldr_addr = 16'h8010;
        bus.ldr_wdata = 16'hDEAD;
        #1;
        total++;
        if (bus.ldr_gnt !== 1'b1 || bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL oor_wr_drop: got lg=%b en=%b we=%b want 1 0 0",
                     bus.ldr_gnt, bus.mem_en, bus.mem_we);
        end
        tick();
        idle_reqs();
        bus.core_req = 1'b1;
        bus.core_addr = 16'h0010;
        tick();
        total++;
        if (bus.core_data !== 16'hBEEF || bus.addr_err !== 1'b1) begin
            bad++;
            $display("FAIL oor_sticky: got cd=%h err=%b want beef 1", bus.core_data, bus.addr_err);
        end
        idle_reqs();
        tick();
    endtask

    task automatic test_mid_reset();
        bus.ldr_req = 1'b1;
        bus.ldr_we = 1'b0;
        bus.ldr_addr = 16'h0030;
        #1;
        total++;
        if (bus.ldr_gnt !== 1'b1) begin
            bad++;
            $display("FAIL midrst_gnt: got lg=%b want 1", bus.ldr_gnt);
        end
        #1;
        rst = 1'b0;
        bus.ldr_req = 1'b0;
        tick();
        total++;
        if (bus.ldr_valid !== 1'b0 || bus.addr_err !== 1'b0 || bus.ldr_rdata !== 16'h0000) begin
            bad++;
            $display("FAIL midrst_discard: got lv=%b err=%b ld=%h want 0 0 0000",
                     bus.ldr_valid, bus.addr_err, bus.ldr_rdata);
        end
        #2;
        rst = 1'b1;
        tick();
        total++;
        if (bus.ldr_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_no_strobe: got lv=%b want 0", bus.ldr_valid);
        end
        bus.core_req = 1'b1;
        bus.core_addr = 16'h0004;
        bus.ldr_req = 1'b1;
        #1;
        total++;
        if (bus.core_gnt !== 1'b1 || bus.ldr_gnt !== 1'b0) begin
            bad++;
            $display("FAIL midrst_rr: got cg=%b lg=%b want 1 0", bus.core_gnt, bus.ldr_gnt);
        end
        tick();
        total++;
        if (bus.core_valid !== 1'b1 || bus.ldr_valid !== 1'b0 || bus.core_data !== 16'h1111) begin
            bad++;
            $display("FAIL midrst_return: got cv=%b lv=%b cd=%h want 1 0 1111",
                     bus.core_valid, bus.ldr_valid, bus.core_data);
        end
        idle_reqs();
        tick();
    endtask

    initial begin
        bus.mem_rdata = 16'h0000;
        test_reset();
        test_core_stream();
        test_contention();
        test_write_then_read();
        test_out_of_range();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
